// File: rtl/score_display.sv
// score_display: turns the selected 16-bit score into five BCD digits with a
// sequential double-dabble engine. It scans those digits onto a multiplexed,
// common-anode seven-segment display. Leading-zero blanking is optional.
module score_display #(
    parameter int REFRESH_DIV   = 50000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] score,
    input  logic [15:0] high_score,
    input  logic        show_high,
    output logic [19:0] bcd,
    output logic        busy,
    output logic [6:0]  seg,
    output logic [4:0]  an
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_bin;
    logic [15:0] r_cap;
    logic [15:0] r_last;
    logic [19:0] r_acc;
    logic [19:0] r_bcd;
    logic [4:0]  r_cnt;
    logic        r_busy;

    logic [RW-1:0] r_refresh_cnt;
    logic [2:0]    r_digit_idx;
    logic [6:0]    r_seg;
    logic [4:0]    r_an;

    logic [15:0] w_sel;
    logic [19:0] w_adj;
    logic [19:0] w_acc_next;
    logic [15:0] w_bin_next;
    logic [4:0]  w_zero_from;
    logic [3:0]  w_nib;
    logic        w_upper_zero;
    logic [6:0]  w_dec;
    logic [6:0]  w_seg_next;
    logic [4:0]  w_an_next;

    assign w_sel = show_high ? high_score : score;

    // Double-dabble correction: any digit of 5 or more gets +3 before the shift.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_adj
            assign w_adj[4*gi +: 4] = (r_acc[4*gi +: 4] >= 4'd5) ?
                                      (r_acc[4*gi +: 4] + 4'd3) : r_acc[4*gi +: 4];
        end
    endgenerate

    // The binary MSB shifts into the BCD LSB. A zero shifts into the binary LSB.
    assign {w_acc_next, w_bin_next} = {w_adj[18:0], r_bin, 1'b0};

    // Conversion FSM. The bcd register changes only in DONE, so it never holds a partial value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_bin   <= '0;
            r_cap   <= '0;
            r_last  <= '0;
            r_acc   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_sel != r_last) begin
                        r_cap   <= w_sel;
                        r_bin   <= w_sel;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_acc <= w_acc_next;
                    r_bin <= w_bin_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd15) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_bcd   <= r_acc;
                    r_last  <= r_cap;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // w_zero_from[i] is set when digit i and every higher digit are zero.
    generate
        for (gi = 0; gi < 5; gi++) begin : g_zero
            assign w_zero_from[gi] = ~|r_bcd[19:4*gi];
        end
    endgenerate

    // Select the digit being scanned, then decode it to active-low segments.
    always_comb begin
        w_nib        = 4'd0;
        w_upper_zero = 1'b0;
        case (r_digit_idx)
            3'd0: begin w_nib = r_bcd[3:0];   w_upper_zero = w_zero_from[0]; end
            3'd1: begin w_nib = r_bcd[7:4];   w_upper_zero = w_zero_from[1]; end
            3'd2: begin w_nib = r_bcd[11:8];  w_upper_zero = w_zero_from[2]; end
            3'd3: begin w_nib = r_bcd[15:12]; w_upper_zero = w_zero_from[3]; end
            3'd4: begin w_nib = r_bcd[19:16]; w_upper_zero = w_zero_from[4]; end
            default: begin w_nib = 4'hF; w_upper_zero = 1'b0; end
        endcase

        case (w_nib)
            4'd0:    w_dec = 7'h40;
            4'd1:    w_dec = 7'h79;
            4'd2:    w_dec = 7'h24;
            4'd3:    w_dec = 7'h30;
            4'd4:    w_dec = 7'h19;
            4'd5:    w_dec = 7'h12;
            4'd6:    w_dec = 7'h02;
            4'd7:    w_dec = 7'h78;
            4'd8:    w_dec = 7'h00;
            4'd9:    w_dec = 7'h10;
            default: w_dec = 7'h7F;
        endcase

        // The units digit is always shown, so a value of zero still reads "0".
        if (BLANK_LEADING && (r_digit_idx != 3'd0) && w_upper_zero) begin
            w_seg_next = 7'h7F;
        end else begin
            w_seg_next = w_dec;
        end

        w_an_next = ~(5'b00001 << r_digit_idx);
    end

    // Digit scan. It runs freely and shows the last completed bcd value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_refresh_cnt <= '0;
            r_digit_idx   <= 3'd0;
            r_seg         <= 7'h7F;
            r_an          <= 5'h1F;
        end else begin
            if (r_refresh_cnt == REFRESH_LAST) begin
                r_refresh_cnt <= '0;
                r_digit_idx   <= (r_digit_idx == 3'd4) ? 3'd0 : (r_digit_idx + 3'd1);
            end else begin
                r_refresh_cnt <= r_refresh_cnt + 1'b1;
            end
            r_seg <= w_seg_next;
            r_an  <= w_an_next;
        end
    end

    assign bcd  = r_bcd;
    assign busy = r_busy;
    assign seg  = r_seg;
    assign an   = r_an;

endmodule
